muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Multi-cycle multiply/divide unit with its scheduler for the 5-stage MIPS core. Sits beside the ALU in E.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and runs a busy counter that models execution latency.
//  Drives a stall request so the hazard logic can hold D while an HI/LO user waits.
//  Cancels any E-stage start when IntReq flushes the E->M register, so a flushed instruction never touches HI/LO.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  IntReq     in   1   interrupt/exception flush; same signal that flushes the E->M register
//  md_op_E    in   3   op in E: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
//  A_E        in   32  rs operand (forwarded)
//  B_E        in   32  rt operand (forwarded)
//  md_use_D   in   1   instruction in D is any md op or MFHI/MFLO
//  Busy       out  1   operation in flight
//  Start      out  1   combinational: md_op_E in 1..4 and !IntReq and !Busy
//  md_stall   out  1   combinational: md_use_D & (Busy | Start)
//  HI         out  32  HI register
//  LO         out  32  LO register
// BEHAVIOUR
//  Reset: state IDLE, Busy=0, cnt=0, HI=0, LO=0, and pending HI/LO = 0. All values are held while reset is high.
//  FSM IDLE:
//   - Start=1: compute the result at this edge into pending regs, load cnt=N-1 (N per op), go to BUSY.
//   - MTHI/MTLO with !IntReq: write A_E into HI/LO at this edge and stay in IDLE.
//   - IntReq=1 suppresses every write and every start in that cycle.
//  FSM BUSY:
//   - Busy=1.
//   - cnt>0: decrement.
//   - cnt==0: commit pending to HI/LO at this edge, Busy falls at the same edge, go to IDLE.
//  Latency: op sampled at edge T0; Busy=1 for exactly N cycles; HI/LO are new from edge T0+N.
//  An md op cannot be in E while Busy, because md_stall holds it in D. If one is present anyway, it is ignored. Start=0 in that case.
//  IntReq while BUSY: no effect. The op already passed E and committed, so it runs to completion.
//  HI/LO outputs keep the old values until commit. MFHI/MFLO are stalled by md_stall, so they never read stale data.
//  MULT: signed 32x32 -> 64; HI=[63:32], LO=[31:0]. MULTU: same, unsigned.
//  DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU: unsigned.
//  Divide by zero: runs the full DIV_CYCLES; at commit HI and LO are left unchanged.
//  DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
//  Reset mid-operation: immediately IDLE, Busy=0, HI=LO=0; the pending result is discarded.
// TESTING
//  1. MULT A=3 B=0xFFFFFFFC -> Busy=1 for 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFF4.
//  2. MULTU A=0xFFFFFFFF B=2 -> HI=1 LO=0xFFFFFFFE.
//  3. DIVU A=7 B=2 -> Busy 10 cycles, LO=3 HI=1.
//  4. DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
//  5. DIV by 0 with HI=0x11, LO=0x22 -> HI/LO stay 0x11/0x22 after 10 cycles.
//  6. MULT with IntReq=1 in the same cycle -> Start=0, Busy stays 0, HI/LO unchanged.
//  7. MTLO A=0x55 with IntReq=0 -> LO=0x55 at the next edge.
//  8. md_use_D=1 during the BUSY window -> md_stall=1 each cycle. md_stall=0 in the cycle Busy falls, provided no new Start.
//  9. Async reset asserted mid-DIV (cycle 4) -> Busy=0, HI=LO=0 before the next edge.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide unit and scheduler for the E stage.
// A start in E computes the result into pending registers at once; a busy counter then
// models the execution latency, and the pending result commits to HI/LO when the counter
// expires. MTHI/MTLO write HI/LO directly when the unit is idle.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset, clears all state
//   IntReq    in   flush of the E->M register; suppresses any start or write this cycle
//   md_op_E   in   op in E: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   A_E, B_E  in   rs / rt operands (forwarded)
//   md_use_D  in   instruction in D is an md op or MFHI/MFLO
//   Busy      out  operation in flight
//   Start     out  an op is accepted this cycle
//   md_stall  out  hold D: an HI/LO user must wait
//   HI, LO    out  architectural HI/LO registers
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IntReq,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        md_use_D,
  output logic        Busy,
  output logic        Start,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_we_q, pend_we_d;

  logic        start;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_u_safe;
  logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;

  // Datapath. Divisors are forced non-zero so the quotient is never X; a zero divisor
  // instead clears the pending write enable and HI/LO are left untouched.
  always_comb begin
    prod_s     = {{32{A_E[31]}}, A_E} * {{32{B_E[31]}}, B_E};
    prod_u     = {32'd0, A_E} * {32'd0, B_E};
    a_mag      = A_E[31] ? (32'd0 - A_E) : A_E;
    b_mag      = B_E[31] ? (32'd0 - B_E) : B_E;
    b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    b_u_safe   = (B_E == 32'd0) ? 32'd1 : B_E;
    // Magnitude divide then re-sign: 0x80000000 / -1 wraps to 0x80000000 rem 0 without a trap.
    sq_mag     = a_mag / b_mag_safe;
    sr_mag     = a_mag % b_mag_safe;
    sq         = (A_E[31] ^ B_E[31]) ? (32'd0 - sq_mag) : sq_mag;
    sr         = A_E[31] ? (32'd0 - sr_mag) : sr_mag;
    uq         = A_E / b_u_safe;
    ur         = A_E % b_u_safe;
  end

  assign start = (md_op_E >= OpMult) && (md_op_E <= OpDivu) && !IntReq && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          unique case (md_op_E)
            OpMult: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_we_d = 1'b1;
              cnt_d     = MultLoad;
            end
            OpMultu: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_we_d = 1'b1;
              cnt_d     = MultLoad;
            end
            OpDiv: begin
              pend_hi_d = sr;
              pend_lo_d = sq;
              pend_we_d = (B_E != 32'd0);
              cnt_d     = DivLoad;
            end
            default: begin
              pend_hi_d = ur;
              pend_lo_d = uq;
              pend_we_d = (B_E != 32'd0);
              cnt_d     = DivLoad;
            end
          endcase
        end else if (!IntReq) begin
          if (md_op_E == OpMthi) hi_d = A_E;
          if (md_op_E == OpMtlo) lo_d = A_E;
        end
      end
      StBusy: begin
        // Any md op seen in E here is ignored; IntReq cannot cancel an op already past E.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StIdle;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign Busy     = (state_q == StBusy);
  assign Start    = start;
  assign md_stall = md_use_D & (Busy | start);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: a table of ops with hand-computed HI/LO and busy lengths,
// followed by directed sequences for ops presented while busy and reset mid-divide.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        IntReq;
  logic [2:0]  md_op_E;
  logic [31:0] A_E, B_E;
  logic        md_use_D;
  logic        Busy, Start, md_stall;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .IntReq   (IntReq),
    .md_op_E  (md_op_E),
    .A_E      (A_E),
    .B_E      (B_E),
    .md_use_D (md_use_D),
    .Busy     (Busy),
    .Start    (Start),
    .md_stall (md_stall),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        irq;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] prev_hi, prev_lo;
    int          cnt;
    logic        stall_bad, hold_bad;

    vecs[0]  = '{"mult_neg",     3'd1, 32'd3,        32'hFFFFFFFC, 1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFF4};
    vecs[1]  = '{"multu_big",    3'd2, 32'hFFFFFFFF, 32'd2,        1'b0, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"divu_7_2",     3'd4, 32'd7,        32'd2,        1'b0, 10, 32'h00000001, 32'h00000003};
    vecs[3]  = '{"div_m7_2",     3'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{"mthi",         3'd5, 32'h11,       32'd0,        1'b0, 0,  32'h00000011, 32'hFFFFFFFD};
    vecs[5]  = '{"mtlo",         3'd6, 32'h22,       32'd0,        1'b0, 0,  32'h00000011, 32'h00000022};
    vecs[6]  = '{"div_by_0",     3'd3, 32'd5,        32'd0,        1'b0, 10, 32'h00000011, 32'h00000022};
    vecs[7]  = '{"mult_irq",     3'd1, 32'd3,        32'd3,        1'b1, 0,  32'h00000011, 32'h00000022};
    vecs[8]  = '{"mtlo_55",      3'd6, 32'h55,       32'd0,        1'b0, 0,  32'h00000011, 32'h00000055};
    vecs[9]  = '{"mthi_irq",     3'd5, 32'h99,       32'd0,        1'b1, 0,  32'h00000011, 32'h00000055};
    vecs[10] = '{"op_reserved",  3'd7, 32'd9,        32'd9,        1'b0, 0,  32'h00000011, 32'h00000055};
    vecs[11] = '{"div_ovf",      3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000};
    vecs[12] = '{"mult_minmin",  3'd1, 32'h80000000, 32'h80000000, 1'b0, 5,  32'h40000000, 32'h00000000};
    vecs[13] = '{"div_7_m2",     3'd3, 32'd7,        32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[14] = '{"multu_ones",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[15] = '{"mult_ones",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5,  32'h00000000, 32'h00000001};

    reset = 1'b1; IntReq = 1'b0; md_op_E = 3'd0; A_E = '0; B_E = '0; md_use_D = 1'b0;
    #3;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_start", {31'd0, Start}, 32'd0);
    #10 reset = 1'b0;

    prev_hi = 32'd0;
    prev_lo = 32'd0;
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      md_op_E = vecs[i].op; A_E = vecs[i].a; B_E = vecs[i].b;
      IntReq = vecs[i].irq; md_use_D = 1'b1;
      #1;
      check({vecs[i].name, "_start"}, {31'd0, Start}, {31'd0, vecs[i].cyc > 0});
      check({vecs[i].name, "_stall0"}, {31'd0, md_stall}, {31'd0, vecs[i].cyc > 0});
      @(posedge clk); #1;
      md_op_E = 3'd0; IntReq = 1'b0;
      cnt = 0; stall_bad = 1'b0; hold_bad = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (!Busy) break;
        cnt++;
        if (md_stall !== 1'b1) stall_bad = 1'b1;
        if (HI !== prev_hi || LO !== prev_lo) hold_bad = 1'b1;
      end
      check({vecs[i].name, "_busy_cycles"}, cnt, vecs[i].cyc);
      check({vecs[i].name, "_stall_busy"}, {31'd0, stall_bad}, 32'd0);
      check({vecs[i].name, "_hold"}, {31'd0, hold_bad}, 32'd0);
      check({vecs[i].name, "_stall_after"}, {31'd0, md_stall}, 32'd0);
      check({vecs[i].name, "_hi"}, HI, vecs[i].hi);
      check({vecs[i].name, "_lo"}, LO, vecs[i].lo);
      prev_hi = vecs[i].hi;
      prev_lo = vecs[i].lo;
      md_use_D = 1'b0;
    end

    // Ops and IntReq arriving while busy must neither start nor write HI/LO.
    @(posedge clk); #1;
    md_op_E = 3'd1; A_E = 32'd2; B_E = 32'd3; IntReq = 1'b0;
    @(posedge clk); #1;
    md_op_E = 3'd4; A_E = 32'd100; B_E = 32'd7; IntReq = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!Busy) break;
      cnt++;
      if (cnt == 1) begin
        check("busy_div_start", {31'd0, Start}, 32'd0);
        md_op_E = 3'd6; A_E = 32'hAA; IntReq = 1'b0;
      end else if (cnt == 2) begin
        check("busy_mtlo_start", {31'd0, Start}, 32'd0);
        md_op_E = 3'd0; IntReq = 1'b1;
      end else begin
        IntReq = 1'b0;
      end
    end
    check("busy_ign_cycles", cnt, 5);
    check("busy_ign_hi", HI, 32'd0);
    check("busy_ign_lo", LO, 32'd6);

    // Asynchronous reset in the fourth busy cycle of a divide.
    @(posedge clk); #1;
    md_op_E = 3'd4; A_E = 32'd100; B_E = 32'd7;
    @(posedge clk); #1;
    md_op_E = 3'd0;
    repeat (4) @(negedge clk);
    check("mid_div_busy", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    md_op_E = 3'd6; A_E = 32'h77;
    @(posedge clk); #1;
    check("rst_hold_lo", LO, 32'd0);
    md_op_E = 3'd0;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_busy", {31'd0, Busy}, 32'd0);
    check("post_rst_lo", LO, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
